// File: rtl/key_serial_sequencer.sv
// Read sequencer for the backplane serial key/ID PAL.
// Sends a 4-nibble unlock sequence, then shifts in NBITS response bits.
module key_serial_sequencer #(
    parameter int          NBITS      = 16,
    parameter int          STROBE_W   = 2,
    parameter int          SETTLE     = 3,
    parameter logic [3:0]  SHIFT_CODE = 4'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [15:0]      req_code,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NBITS-1:0] rdata,
    output logic             dev_sel_n,
    output logic [3:0]       dev_a,
    output logic             dev_wr,
    output logic             dev_stb,
    input  logic             dev_dout
);

    localparam int STEPS = NBITS + 4;
    localparam int SW    = $clog2(STEPS);
    localparam int CMAX  = (STROBE_W > SETTLE) ? STROBE_W : SETTLE;
    localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, STB, HOLD, DONE} state_t;

    state_t           state, state_nx;
    logic [SW-1:0]    step, step_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [15:0]      code, code_src;
    logic [NBITS-1:0] shreg, word;
    logic [3:0]       a_nx;
    logic             start, sample, finish, active_nx;

    assign word = {shreg[NBITS-2:0], dev_dout};

    always_comb begin
        state_nx  = state;
        step_nx   = step;
        cnt_nx    = cnt;
        start     = 1'b0;
        sample    = 1'b0;
        finish    = 1'b0;
        active_nx = 1'b0;
        code_src  = code;
        a_nx      = SHIFT_CODE;

        case (state)
            IDLE:  start = req && !abort;
            SETUP: begin
                state_nx = STB;
                cnt_nx   = '0;
            end
            STB: begin
                if (cnt == CW'(STROBE_W - 1)) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt == CW'(SETTLE - 1)) begin
                    sample = (step >= SW'(4));
                    cnt_nx = '0;
                    if (step == SW'(STEPS - 1)) begin
                        finish   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        state_nx = SETUP;
                        step_nx  = step + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                // A held req restarts straight out of DONE, one cycle after done
                start    = req && !abort;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (start) begin
            state_nx = SETUP;
            step_nx  = '0;
            cnt_nx   = '0;
        end

        if (abort && state != IDLE) begin
            state_nx = IDLE;
            step_nx  = '0;
            cnt_nx   = '0;
            start    = 1'b0;
            sample   = 1'b0;
            finish   = 1'b0;
        end

        active_nx = (state_nx == SETUP) || (state_nx == STB) ||
                    (state_nx == HOLD);
        code_src  = start ? req_code : code;
        if (step_nx < SW'(4)) begin
            unique case (step_nx[1:0])
                2'd0: a_nx = code_src[15:12];
                2'd1: a_nx = code_src[11:8];
                2'd2: a_nx = code_src[7:4];
                2'd3: a_nx = code_src[3:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= '0;
            cnt   <= '0;
            code  <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
            cnt   <= cnt_nx;
            if (start)  code  <= req_code;
            if (sample) shreg <= word;
        end
    end

    // Outputs are registered from the next state so the bus never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            dev_sel_n <= 1'b1;
            dev_a     <= 4'h0;
            dev_wr    <= 1'b0;
            dev_stb   <= 1'b0;
        end else begin
            busy      <= active_nx;
            done      <= (state_nx == DONE);
            dev_sel_n <= !active_nx;
            dev_wr    <= active_nx;
            dev_stb   <= (state_nx == STB);
            dev_a     <= active_nx ? a_nx : 4'h0;
            if (finish) begin
                rdata <= word;
                err   <= &word;
            end
        end
    end

endmodule

// File: tb/tb_key_serial_sequencer.sv
// Directed bench for key_serial_sequencer: default build plus a short
// NBITS=8 / STROBE_W=1 / SETTLE=1 build, each with a small PAL model.
module tb_key_serial_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_a = 0, abort_a = 0, dout_a = 0;
    logic [15:0] code_a = 0;
    logic        busy_a, done_a, err_a, sel_a, wr_a, stb_a;
    logic [15:0] rdata_a;
    logic [3:0]  a_a;

    logic        req_b = 0, abort_b = 0, dout_b = 0;
    logic [15:0] code_b = 0;
    logic        busy_b, done_b, err_b, sel_b, wr_b, stb_b;
    logic [7:0]  rdata_b;
    logic [3:0]  a_b;

    key_serial_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .req_code(code_a),
        .abort(abort_a), .busy(busy_a), .done(done_a), .err(err_a),
        .rdata(rdata_a), .dev_sel_n(sel_a), .dev_a(a_a), .dev_wr(wr_a),
        .dev_stb(stb_a), .dev_dout(dout_a)
    );

    key_serial_sequencer #(.NBITS(8), .STROBE_W(1), .SETTLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .req_code(code_b),
        .abort(abort_b), .busy(busy_b), .done(done_b), .err(err_b),
        .rdata(rdata_b), .dev_sel_n(sel_b), .dev_a(a_b), .dev_wr(wr_b),
        .dev_stb(stb_b), .dev_dout(dout_b)
    );

    int nvec = 0;
    int nbad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // PAL models: count strobes, log dev_a, present response MSB-first
    logic [15:0] resp_a = 0;
    logic [7:0]  resp_b = 0;
    logic [3:0]  seq_a[32], seq_b[32];
    int rc_a[32], rc_b[32];
    int na = 0, nb = 0, na_tot = 0;
    int wcur_a = 0, wlast_a = 0, wcur_b = 0, wlast_b = 0;
    int astab_bad = 0, gap = 0;
    logic spa = 0, spb = 0, mon_en = 0;

    always @(negedge clk) begin
        if (!busy_a) begin
            if (na != 0) na_tot = na;
            na = 0;
        end else if (stb_a && !spa) begin
            if (na < 32) begin
                seq_a[na] = a_a;
                rc_a[na]  = cyc;
            end
            na++;
            if (na >= 5 && na <= 20) dout_a = resp_a[20-na];
        end
        if (stb_a) begin
            wcur_a++;
            if (na >= 1 && na <= 32 && a_a !== seq_a[na-1]) astab_bad++;
            if (!wr_a || sel_a) astab_bad++;
        end else if (spa) begin
            wlast_a = wcur_a;
            wcur_a  = 0;
        end
        spa = stb_a;
        if (mon_en && !busy_a && !done_a) gap++;
    end

    always @(negedge clk) begin
        if (!busy_b) begin
            nb = 0;
        end else if (stb_b && !spb) begin
            if (nb < 32) begin
                seq_b[nb] = a_b;
                rc_b[nb]  = cyc;
            end
            nb++;
            if (nb >= 5 && nb <= 12) dout_b = resp_b[12-nb];
        end
        if (stb_b) begin
            wcur_b++;
            if (nb >= 1 && nb <= 32 && a_b !== seq_b[nb-1]) astab_bad++;
        end else if (spb) begin
            wlast_b = wcur_b;
            wcur_b  = 0;
        end
        spb = stb_b;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // k = edge that accepts req; done cycle number = edges seen + 1
    task automatic start(input bit sel, output int k);
        tick();
        k = cyc + 1;
        if (sel) req_b = 1'b1;
        else     req_a = 1'b1;
        tick();
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((sel ? done_b : done_a) === 1'b1) begin
                dc = cyc + 1;
                break;
            end
        end
    endtask

    task automatic wait_na(input int n, input bit want_stb, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (na == n && stb_a == want_stb) return;
            tick();
        end
        chk("wait_na_timeout", 1, 0);
    endtask

    int k, dc, d1, d2, d3, ndone;
    logic [15:0] useq;
    logic [3:0]  sor;

    initial begin
        repeat (3) tick();
        chk("rst_a", {busy_a, done_a, err_a, rdata_a, sel_a, a_a, wr_a, stb_a},
            {3'b000, 16'h0000, 1'b1, 4'h0, 2'b00});
        chk("rst_b", {busy_b, done_b, err_b, rdata_b, sel_b, a_b, wr_b, stb_b},
            {3'b000, 8'h00, 1'b1, 4'h0, 2'b00});
        rst_n = 1'b1;
        repeat (2) tick();

        // all-ones device, then a real word clears err
        resp_a = 16'hFFFF;
        code_a = 16'h1111;
        start(0, k);
        chk("busy_on", busy_a, 1);
        wait_done(0, 200, dc);
        chk("lat_ff", dc, k + 121);
        chk("rdata_ff", rdata_a, 16'hFFFF);
        chk("err_ff", err_a, 1);
        chk("busy_done", busy_a, 0);
        resp_a = 16'h0001;
        start(0, k);
        wait_done(0, 200, dc);
        chk("rdata_01", rdata_a, 16'h0001);
        chk("err_01", err_a, 0);

        // nominal read
        resp_a = 16'h1234;
        code_a = 16'hA53C;
        start(0, k);
        wait_done(0, 200, dc);
        chk("lat_1234", dc, k + 121);
        chk("rdata_1234", rdata_a, 16'h1234);
        chk("err_1234", err_a, 0);
        useq = {seq_a[0], seq_a[1], seq_a[2], seq_a[3]};
        chk("unlock_a", useq, 16'hA53C);
        sor = 4'h0;
        for (int i = 4; i < 20; i++) sor = sor | seq_a[i];
        chk("shift_code", sor, 4'h0);
        chk("nstrobes", na_tot, 20);
        chk("stb_w_a", wlast_a, 2);
        chk("step_a", rc_a[5] - rc_a[4], 6);
        tick();
        chk("done_pulse", done_a, 0);

        // abort in STB of shift step 7 (12th strobe)
        resp_a = 16'h0F0F;
        start(0, k);
        wait_na(12, 1'b1, 200);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_idle", {busy_a, sel_a, stb_a, wr_a}, 4'b0100);
        ndone = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (done_a) ndone++;
        end
        chk("abort_nodone", ndone, 0);
        chk("abort_rdata", rdata_a, 16'h1234);
        chk("abort_err", err_a, 0);

        // abort beats req in IDLE
        tick();
        req_a   = 1'b1;
        abort_a = 1'b1;
        tick();
        req_a   = 1'b0;
        abort_a = 1'b0;
        tick();
        chk("abort_wins", busy_a, 0);

        // held req: back-to-back transactions
        resp_a = 16'h5AC3;
        tick();
        req_a = 1'b1;
        wait_done(0, 200, d1);
        mon_en = 1'b1;
        wait_done(0, 200, d2);
        wait_done(0, 200, d3);
        mon_en = 1'b0;
        req_a  = 1'b0;
        chk("b2b_gap1", d2 - d1, 121);
        chk("b2b_gap2", d3 - d2, 121);
        chk("b2b_busy", gap, 0);
        chk("b2b_rdata", rdata_a, 16'h5AC3);
        repeat (2) tick();
        chk("b2b_stop", busy_a, 0);

        // async reset in HOLD of unlock step 2
        resp_a = 16'h1234;
        start(0, k);
        wait_na(3, 1'b1, 200);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {busy_a, done_a, err_a, rdata_a, sel_a, a_a, wr_a, stb_a},
            {3'b000, 16'h0000, 1'b1, 4'h0, 2'b00});
        tick();
        rst_n = 1'b1;
        tick();
        start(0, k);
        wait_done(0, 200, dc);
        chk("rst_lat", dc, k + 121);
        chk("rst_rdata", rdata_a, 16'h1234);

        // short build; req_code changed mid-unlock must be ignored
        resp_b = 8'hA7;
        code_b = 16'h3C5A;
        start(1, k);
        for (int i = 0; i < 50 && nb < 2; i++) tick();
        code_b = 16'hFFFF;
        wait_done(1, 100, dc);
        chk("b_lat", dc, k + 37);
        chk("b_rdata", rdata_b, 8'hA7);
        chk("b_err", err_b, 0);
        useq = {seq_b[0], seq_b[1], seq_b[2], seq_b[3]};
        chk("b_unlock", useq, 16'h3C5A);
        chk("b_stb_w", wlast_b, 1);
        chk("b_step", rc_b[6] - rc_b[5], 3);

        chk("bus_stable", astab_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
